// File: rtl/voxel_span_renderer.sv
// rtl/voxel_span_renderer.sv - front-to-back voxel ray marcher with occluded span fill and pixel backpressure
module voxel_span_renderer #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int HORIZON_Y   = 120,
    parameter int DEPTH_STEPS = 512,
    parameter int POS_INT     = 8,
    parameter int POS_FRAC    = 16,
    parameter int H_W         = 8,
    parameter int COLOR_W     = 3,
    parameter int SCALE_W     = 27,
    parameter int SCALE_FRAC  = 18,
    parameter int EYE_HEIGHT  = 2,
    parameter int MEM_LAT     = 2
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             start,
    input  logic                             mode,
    input  logic [POS_INT+POS_FRAC-1:0]      pos_x,
    input  logic [POS_INT+POS_FRAC-1:0]      pos_y,
    input  logic [POS_INT+POS_FRAC-1:0]      dir_x,
    input  logic [POS_INT+POS_FRAC-1:0]      dir_y,
    input  logic [POS_INT+POS_FRAC-1:0]      perp_x,
    input  logic [POS_INT+POS_FRAC-1:0]      perp_y,
    output logic [2*POS_INT-1:0]             map_addr,
    input  logic [H_W-1:0]                   map_height,
    input  logic [COLOR_W-1:0]               map_color,
    output logic [$clog2(DEPTH_STEPS)-1:0]   scale_addr,
    input  logic [SCALE_W-1:0]               scale_data,
    output logic                             fb_we,
    output logic [$clog2(SCREEN_W)-1:0]      fb_x,
    output logic [$clog2(SCREEN_H)-1:0]      fb_y,
    output logic [COLOR_W-1:0]               fb_color,
    input  logic                             fb_ready,
    output logic                             busy,
    output logic                             done
);
    localparam int PW  = POS_INT + POS_FRAC;
    localparam int XW  = $clog2(SCREEN_W);
    localparam int YW  = $clog2(SCREEN_H);
    localparam int YBW = $clog2(SCREEN_H + 1);
    localparam int DW  = $clog2(DEPTH_STEPS);
    localparam int CW  = $clog2(SCREEN_W + 1);
    localparam int LW  = $clog2(MEM_LAT + 1);
    localparam int PRW = SCALE_W + H_W + 3;

    typedef enum logic [3:0] {
        S_IDLE, S_EYE, S_CLEAR, S_ROW_INIT, S_FETCH,
        S_WAIT, S_PROJECT, S_SPAN, S_NEXT, S_DONE
    } state_t;

    state_t           state;
    logic             mode_r;
    logic [PW-1:0]    dir_x_r, dir_y_r, perp_x_r, perp_y_r;
    logic [PW-1:0]    left_x, left_y, step_x, step_y, smp_x, smp_y;
    logic [H_W:0]     eye_h;
    logic [XW-1:0]    col, clr_idx;
    logic [DW-1:0]    depth;
    logic [LW-1:0]    wait_cnt;
    logic [CW-1:0]    closed_cnt;
    logic [YW-1:0]    top_r;

    // ybuf[c] is the lowest row already painted in column c; SCREEN_H means nothing painted yet
    logic [YBW-1:0]   ybuf [SCREEN_W];
    logic [YBW-1:0]   ybuf_rd;
    logic             ybuf_we;
    logic [XW-1:0]    ybuf_wa;
    logic [YBW-1:0]   ybuf_wd;

    logic signed [PRW-1:0] scale_s, diff_s, prod, ht;
    logic [YW-1:0]    top_v, start_row;
    logic             visible, span_needed;

    assign ybuf_rd = ybuf[col];

    always_comb begin
        scale_s     = $signed(PRW'(scale_data));
        diff_s      = $signed(PRW'(map_height)) - $signed(PRW'(eye_h));
        prod        = scale_s * diff_s;
        ht          = (prod >>> SCALE_FRAC) + $signed(PRW'(HORIZON_Y));
        visible     = !ht[PRW-1];
        if (ht > $signed(PRW'(SCREEN_H - 1)))
            top_v = '0;
        else
            top_v = YW'(SCREEN_H - 1) - ht[YW-1:0];
        span_needed = !mode_r || (YBW'(top_v) < ybuf_rd);
        start_row   = mode_r ? YW'(ybuf_rd - YBW'(1)) : top_v;
    end

    always_comb begin
        ybuf_we = 1'b0;
        ybuf_wa = clr_idx;
        ybuf_wd = YBW'(SCREEN_H);
        if (state == S_CLEAR) begin
            ybuf_we = 1'b1;
        end else if (state == S_SPAN && mode_r && fb_ready && fb_y == top_r) begin
            ybuf_we = 1'b1;
            ybuf_wa = col;
            ybuf_wd = YBW'(top_r);
        end
    end

    always_ff @(posedge Clk) begin
        if (ybuf_we)
            ybuf[ybuf_wa] <= ybuf_wd;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fb_we      <= 1'b0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_color   <= '0;
            map_addr   <= '0;
            scale_addr <= '0;
            mode_r     <= 1'b0;
            dir_x_r    <= '0;
            dir_y_r    <= '0;
            perp_x_r   <= '0;
            perp_y_r   <= '0;
            left_x     <= '0;
            left_y     <= '0;
            step_x     <= '0;
            step_y     <= '0;
            smp_x      <= '0;
            smp_y      <= '0;
            eye_h      <= '0;
            col        <= '0;
            clr_idx    <= '0;
            depth      <= '0;
            wait_cnt   <= '0;
            closed_cnt <= '0;
            top_r      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        dir_x_r  <= dir_x;
                        dir_y_r  <= dir_y;
                        perp_x_r <= perp_x;
                        perp_y_r <= perp_y;
                        left_x   <= pos_x;
                        left_y   <= pos_y;
                        step_x   <= '0;
                        step_y   <= '0;
                        map_addr <= {pos_y[PW-1:POS_FRAC], pos_x[PW-1:POS_FRAC]};
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_EYE;
                    end
                end
                S_EYE: begin
                    if (wait_cnt == LW'(MEM_LAT)) begin
                        eye_h      <= (H_W+1)'(map_height) + (H_W+1)'(EYE_HEIGHT);
                        clr_idx    <= '0;
                        closed_cnt <= '0;
                        depth      <= '0;
                        state      <= S_CLEAR;
                    end else begin
                        wait_cnt <= wait_cnt + LW'(1);
                    end
                end
                S_CLEAR: begin
                    clr_idx <= clr_idx + XW'(1);
                    if (clr_idx == XW'(SCREEN_W - 1))
                        state <= S_ROW_INIT;
                end
                S_ROW_INIT: begin
                    left_x <= left_x + dir_x_r;
                    left_y <= left_y + dir_y_r;
                    step_x <= step_x + perp_x_r;
                    step_y <= step_y + perp_y_r;
                    smp_x  <= left_x + dir_x_r;
                    smp_y  <= left_y + dir_y_r;
                    col    <= '0;
                    state  <= S_FETCH;
                end
                S_FETCH: begin
                    if (mode_r && ybuf_rd == '0) begin
                        state <= S_NEXT;
                    end else begin
                        map_addr   <= {smp_y[PW-1:POS_FRAC], smp_x[PW-1:POS_FRAC]};
                        scale_addr <= depth;
                        wait_cnt   <= LW'(1);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LW'(MEM_LAT))
                        state <= S_PROJECT;
                    else
                        wait_cnt <= wait_cnt + LW'(1);
                end
                S_PROJECT: begin
                    if (!visible || !span_needed) begin
                        state <= S_NEXT;
                    end else begin
                        fb_we    <= 1'b1;
                        fb_x     <= col;
                        fb_y     <= start_row;
                        fb_color <= map_color;
                        top_r    <= top_v;
                        state    <= S_SPAN;
                    end
                end
                S_SPAN: begin
                    // rows walk upward from the occlusion line to top, one per accepted write
                    if (fb_ready) begin
                        if (fb_y == top_r) begin
                            fb_we <= 1'b0;
                            if (mode_r && top_r == '0)
                                closed_cnt <= closed_cnt + CW'(1);
                            state <= S_NEXT;
                        end else begin
                            fb_y <= fb_y - YW'(1);
                        end
                    end
                end
                S_NEXT: begin
                    smp_x <= smp_x + step_x;
                    smp_y <= smp_y + step_y;
                    if ((mode_r && closed_cnt == CW'(SCREEN_W)) ||
                        (col == XW'(SCREEN_W - 1) && depth == DW'(DEPTH_STEPS - 1))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (col == XW'(SCREEN_W - 1)) begin
                        depth <= depth + DW'(1);
                        state <= S_ROW_INIT;
                    end else begin
                        col   <= col + XW'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voxel_span_renderer.sv
// tb/tb_voxel_span_renderer.sv - self-checking bench for voxel_span_renderer against a frame-level model
`timescale 1ns/1ps
module tb_voxel_span_renderer;
    localparam int SW = 4, SH = 8, DS = 4, HY = 4, SF = 0, EH = 2;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0;
    logic [23:0] pos_x = '0, pos_y = '0, dir_x = '0, dir_y = '0, perp_x = '0, perp_y = '0;
    logic [15:0] map_addr;
    logic [7:0]  map_height;
    logic [2:0]  map_color;
    logic [1:0]  scale_addr;
    logic [26:0] scale_data;
    logic        fb_we, fb_ready = 1'b1, busy, done;
    logic [1:0]  fb_x;
    logic [2:0]  fb_y, fb_color;

    voxel_span_renderer #(
        .SCREEN_W(SW), .SCREEN_H(SH), .HORIZON_Y(HY), .DEPTH_STEPS(DS),
        .POS_INT(8), .POS_FRAC(16), .H_W(8), .COLOR_W(3), .SCALE_W(27),
        .SCALE_FRAC(SF), .EYE_HEIGHT(EH), .MEM_LAT(2)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .start(start), .mode(mode),
        .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
        .perp_x(perp_x), .perp_y(perp_y),
        .map_addr(map_addr), .map_height(map_height), .map_color(map_color),
        .scale_addr(scale_addr), .scale_data(scale_data),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_ready(fb_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    int          rom_kind = 0, dir_h = 0, dir_scale = 0;
    logic [15:0] seed = '0;
    int          sc_tab [DS];

    function automatic int th(input logic [15:0] a);
        logic [15:0] m;
        if (rom_kind == 0) return (a == 16'h0) ? 0 : dir_h;
        m = (a * 16'd40503) ^ seed;
        return int'(m >> 4) % 12;
    endfunction

    function automatic logic [2:0] tc(input logic [15:0] a);
        return a[2:0] ^ a[10:8];
    endfunction

    function automatic int sc(input int d);
        return (rom_kind == 0) ? dir_scale : sc_tab[d];
    endfunction

    // two-edge ROM latency: address register stage, then data register stage
    logic [15:0] ma_p;
    logic [1:0]  sa_p;
    always @(posedge clk) begin
        ma_p       <= map_addr;
        sa_p       <= scale_addr;
        map_height <= 8'(th(ma_p));
        map_color  <= tc(ma_p);
        scale_data <= 27'(sc(int'(sa_p)));
    end

    logic [7:0]  exp_q[$], got_q[$];
    logic [23:0] lpx, lpy, ldx, ldy, lqx, lqy;
    int          done_cnt, stall_viol, seen_x;
    bit          busy_seen, busy_at_done, timed_out, post_act;
    logic [28:0] rst_snap;

    function automatic logic [7:0] pix(input logic [2:0] c, input int x, input int y);
        return {c, 2'(x), 3'(y)};
    endfunction

    task automatic model_frame(input bit md);
        logic [23:0] lx, ly, cx, cy, sx, sy;
        logic [15:0] a;
        int yb [SW];
        int closed, eye, ht, top;
        bit stop;
        exp_q.delete();
        eye = th({lpy[23:16], lpx[23:16]}) + EH;
        lx = lpx; ly = lpy; cx = '0; cy = '0; closed = 0; stop = 0;
        for (int c = 0; c < SW; c++) yb[c] = SH;
        for (int d = 0; d < DS && !stop; d++) begin
            lx = lx + ldx; ly = ly + ldy; cx = cx + lqx; cy = cy + lqy;
            sx = lx; sy = ly;
            for (int c = 0; c < SW && !stop; c++) begin
                if (!(md && yb[c] == 0)) begin
                    a  = {sy[23:16], sx[23:16]};
                    ht = ((sc(d) * (th(a) - eye)) >>> SF) + HY;
                    if (ht >= 0) begin
                        top = SH - 1 - ((ht > SH - 1) ? SH - 1 : ht);
                        if (!md) begin
                            exp_q.push_back(pix(tc(a), c, top));
                        end else if (top < yb[c]) begin
                            for (int y = yb[c] - 1; y >= top; y--) exp_q.push_back(pix(tc(a), c, y));
                            yb[c] = top;
                            if (top == 0) closed++;
                        end
                    end
                end
                sx = sx + cx; sy = sy + cy;
                if (md && closed == SW) stop = 1;
            end
        end
    endtask

    function automatic int seq_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        return (got_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    // rk: 0 ready always, 1 random ready, 2 one 5-cycle stall after two pixels
    task automatic run_frame(input bit md, input int rk, input int rst_at, input bit scramble, input bit poke);
        int cyc, stall_rem;
        bit ended, stall_started, stalled_prev;
        logic [7:0] held;
        got_q.delete();
        done_cnt = 0; stall_viol = 0; seen_x = 0; post_act = 0; busy_at_done = 1;
        lpx = pos_x; lpy = pos_y; ldx = dir_x; ldy = dir_y; lqx = perp_x; lqy = perp_y;
        model_frame(md);
        @(negedge clk); mode = md; start = 1'b1;
        @(negedge clk); start = 1'b0; busy_seen = busy;
        if (scramble) begin
            mode = ~md; pos_x = 24'($urandom); pos_y = 24'($urandom);
            dir_x = 24'($urandom); dir_y = 24'($urandom); perp_x = 24'($urandom); perp_y = 24'($urandom);
        end
        cyc = 0; stall_rem = 0; stall_started = 0; stalled_prev = 0; ended = 0; held = '0;
        while (!ended && cyc < 4000) begin
            case (rk)
                1: fb_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stall_started && got_q.size() == 2) begin stall_started = 1; stall_rem = 5; end
                    fb_ready = (stall_rem == 0);
                    if (stall_rem > 0) stall_rem--;
                end
                default: fb_ready = 1'b1;
            endcase
            if (poke) start = (cyc == 10);
            if (stalled_prev && (!fb_we || {fb_color, fb_x, fb_y} !== held)) stall_viol++;
            stalled_prev = fb_we && !fb_ready;
            held = {fb_color, fb_x, fb_y};
            if (fb_we && fb_ready) got_q.push_back({fb_color, fb_x, fb_y});
            if (map_addr[15:3] == '0) seen_x = seen_x | (1 << map_addr[2:0]);
            if (done) begin done_cnt++; busy_at_done = busy; ended = 1; end
            if (rst_at > 0 && got_q.size() == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_snap = {fb_we, done, busy, fb_x, fb_y, fb_color, map_addr, scale_addr};
                ended = 1;
            end
            if (!ended) @(negedge clk);
            cyc++;
        end
        start = 1'b0; fb_ready = 1'b1;
        timed_out = !ended;
        if (ended && rst_at == 0) begin
            repeat (4) begin
                @(negedge clk);
                if (busy || fb_we || done) post_act = 1;
            end
        end
    endtask

    task automatic set_directed(input int h, input int s);
        rom_kind = 0; dir_h = h; dir_scale = s;
        pos_x = '0; pos_y = '0; dir_x = 24'h010000; dir_y = '0; perp_x = '0; perp_y = '0;
    endtask

    task automatic set_random();
        rom_kind = 1; seed = 16'($urandom);
        for (int d = 0; d < DS; d++) sc_tab[d] = $urandom_range(0, 3);
        pos_x = 24'($urandom); pos_y = 24'($urandom); dir_x = 24'($urandom);
        dir_y = 24'($urandom); perp_x = 24'($urandom); perp_y = 24'($urandom);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fb_we, done, busy, fb_x, fb_y, fb_color, map_addr, scale_addr} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {fb_we, done, busy, fb_x, fb_y, fb_color, map_addr, scale_addr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_span_basic();
        int md;
        set_directed(2, 1);
        run_frame(1'b1, 0, 0, 1'b0, 1'b0);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL span_busy_rise got=%b want=1", busy_seen); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL span_timeout got=%b want=0", timed_out); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL span_done got=%0d want=1", done_cnt); end
        checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL span_count got=%0d want=20", got_q.size()); end
        md = seq_diff();
        checks++; if (md !== -1) begin errors++; $display("FAIL span_seq first_diff=%0d want=-1", md); end
        checks++; if (got_q.size() > 0 && got_q[0] !== pix(3'd1, 0, 7)) begin errors++; $display("FAIL span_first got=%h want=%h", got_q[0], pix(3'd1, 0, 7)); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL span_busy_at_done got=%b want=0", busy_at_done); end
        checks++; if (post_act !== 1'b0) begin errors++; $display("FAIL span_post_idle got=%b want=0", post_act); end
        checks++; if (seen_x[4] !== 1'b1) begin errors++; $display("FAIL span_last_depth_fetch got=%b want=1", seen_x[4]); end
    endtask

    task automatic test_point_mode();
        int bad_y, md;
        set_directed(2, 1);
        run_frame(1'b0, 0, 0, 1'b0, 1'b0);
        bad_y = 0;
        foreach (got_q[i]) if (got_q[i][2:0] !== 3'd3) bad_y++;
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL point_count got=%0d want=16", got_q.size()); end
        checks++; if (bad_y !== 0) begin errors++; $display("FAIL point_row got=%0d off-row want=0", bad_y); end
        md = seq_diff();
        checks++; if (md !== -1) begin errors++; $display("FAIL point_seq first_diff=%0d want=-1", md); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL point_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_early_close();
        int md;
        set_directed(10, 1);
        run_frame(1'b1, 0, 0, 1'b0, 1'b0);
        checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL close_count got=%0d want=32", got_q.size()); end
        md = seq_diff();
        checks++; if (md !== -1) begin errors++; $display("FAIL close_seq first_diff=%0d want=-1", md); end
        checks++; if (seen_x[2] !== 1'b0) begin errors++; $display("FAIL close_depth1_fetch got=%b want=0", seen_x[2]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL close_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_invisible();
        set_directed(0, 4);
        run_frame(1'b1, 0, 0, 1'b0, 1'b0);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL invis_count got=%0d want=0", got_q.size()); end
        checks++; if (seen_x[4] !== 1'b1) begin errors++; $display("FAIL invis_all_depths got=%b want=1", seen_x[4]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL invis_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit [31:0] cover_xy;
        int md, distinct;
        set_directed(2, 1);
        run_frame(1'b1, 2, 0, 1'b0, 1'b0);
        cover_xy = '0;
        foreach (got_q[i]) cover_xy[got_q[i][4:0]] = 1'b1;
        distinct = $countones(cover_xy);
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_hold got=%0d violations want=0", stall_viol); end
        checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL bp_count got=%0d want=20", got_q.size()); end
        checks++; if (distinct !== 20) begin errors++; $display("FAIL bp_distinct got=%0d want=20", distinct); end
        md = seq_diff();
        checks++; if (md !== -1) begin errors++; $display("FAIL bp_seq first_diff=%0d want=-1", md); end
    endtask

    task automatic test_reset_mid_span();
        int md;
        set_directed(2, 1);
        run_frame(1'b1, 0, 3, 1'b0, 1'b0);
        checks++; if (rst_snap !== 29'd0) begin errors++; $display("FAIL midreset_outputs got=%h want=0", rst_snap); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b1, 0, 0, 1'b0, 1'b0);
        checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL midreset_count got=%0d want=20", got_q.size()); end
        md = seq_diff();
        checks++; if (md !== -1) begin errors++; $display("FAIL midreset_seq first_diff=%0d want=-1", md); end
    endtask

    task automatic test_random();
        int md;
        for (int it = 0; it < 10; it++) begin
            set_random();
            run_frame(1'($urandom_range(0, 1)), 1, 0, 1'b1, 1'b0);
            md = seq_diff();
            checks++; if (timed_out !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done got=%0d timeout=%b want=1", it, done_cnt, timed_out); end
            checks++; if (md !== -1) begin errors++; $display("FAIL rand%0d_seq first_diff=%0d got_n=%0d want_n=%0d", it, md, got_q.size(), exp_q.size()); end
            checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rand%0d_hold got=%0d want=0", it, stall_viol); end
        end
    endtask

    task automatic test_back_to_back();
        int md;
        for (int it = 0; it < 2; it++) begin
            set_random();
            run_frame(1'b1, 1, 0, 1'b0, 1'b1);
            md = seq_diff();
            checks++; if (done_cnt !== 1 || post_act !== 1'b0) begin errors++; $display("FAIL b2b%0d_single_frame done=%0d post=%b want=1,0", it, done_cnt, post_act); end
            checks++; if (md !== -1) begin errors++; $display("FAIL b2b%0d_seq first_diff=%0d want=-1", it, md); end
        end
    endtask

    initial begin
        test_reset();
        test_span_basic();
        test_point_mode();
        test_early_close();
        test_invisible();
        test_backpressure();
        test_reset_mid_span();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
